// File: rtl/dot_stream_pkg.sv
// dot_stream_pkg: shared register map, status bit positions and FSM state encoding.
package dot_stream_pkg;
    localparam logic [3:0] REG_CTRL  = 4'd0;
    localparam logic [3:0] REG_BASE1 = 4'd1;
    localparam logic [3:0] REG_BASE2 = 4'd2;
    localparam logic [3:0] REG_LEN   = 4'd3;
    localparam logic [3:0] REG_STR1  = 4'd4;
    localparam logic [3:0] REG_STR2  = 4'd5;
    localparam logic [3:0] REG_STAT  = 4'd6;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FLUSH} state_e;
endpackage

// File: rtl/dot_stream_mac.sv
// dot_stream_mac: 2-stage signed fixed-point multiply / slice / accumulate.
// Ports: clk, rst_n (async, active-low); clr_i clears accumulator and overflow;
//        vld_i qualifies a_i x b_i; acc_o running sum; ovf_o sticky clamp flag.
// Build option: DOT_SATURATE_EN clamps the accumulator instead of wrapping.
module dot_stream_mac #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              ovf_o
);
    logic [2*DATA_W-1:0] full;
    logic [DATA_W-1:0]   prod_q, acc_q, acc_d, add;
    logic                pv_q, ovf_q, ovf_d, sat;
    logic                unused_bits;

    // Sign-extending both operands makes the low 2*DATA_W bits of an unsigned multiply the signed product.
    assign full = {{DATA_W{a_i[DATA_W-1]}}, a_i} * {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign unused_bits = ^{full[FRAC_W-1:0], full[2*DATA_W-1:FRAC_W+DATA_W]};

`ifdef DOT_SATURATE_EN
    logic [DATA_W:0] sum;
    assign sum = {acc_q[DATA_W-1], acc_q} + {prod_q[DATA_W-1], prod_q};
    assign sat = sum[DATA_W] ^ sum[DATA_W-1];
    // On overflow the true sign sits in the extra bit: build max or min from it.
    assign add = sat ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];
`else
    assign add = acc_q + prod_q;
    assign sat = 1'b0;
`endif

    always_comb begin
        acc_d = clr_i ? '0 : (pv_q ? add : acc_q);
        ovf_d = clr_i ? 1'b0 : ovf_q | (pv_q & sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= full[FRAC_W+DATA_W-1:FRAC_W];
            pv_q   <= vld_i && !clr_i;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/dot_stream.sv
// dot_stream: CPU-programmed fixed-point dot-product engine with a pipelined read master.
// Ports: clk, rst_n (async, active-low);
//        slave_*  Avalon-MM register slave (0 start/result, 1-2 bases, 3 length,
//                 4-5 byte strides, 6 status {ovf,done,busy});
//        master_* Avalon-MM read master, up to MAX_OUT reads in flight; writes tied off.
// Build option: DOT_SATURATE_EN selects a saturating accumulator with sticky overflow.
module dot_stream
    import dot_stream_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    output logic [31:0] slave_readdata,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    localparam int OW = $clog2(MAX_OUT + 1);

    state_e            state_q, state_d;
    logic [31:0]       base1_q, base2_q, len_q, str1_q, str2_q;
    logic [31:0]       addr1_q, addr1_d, addr2_q, addr2_d, s1_q, s1_d, s2_q, s2_d, rem_q, rem_d;
    logic [OW-1:0]     out_q, out_d;
    logic              iph_q, iph_d, rph_q, rph_d, flush_q, flush_d, done_q, done_d;
    logic [DATA_W-1:0] v1_q, v1_d, acc;
    logic              ovf, busy, start, accept, rvalid;

    assign busy              = state_q != S_IDLE;
    assign start             = slave_write && slave_address == REG_CTRL && !busy;
    assign slave_waitrequest = busy && slave_address == REG_CTRL && (slave_read || slave_write);
    assign master_read       = state_q == S_ISSUE && out_q < OW'(MAX_OUT);
    // iph_q selects which vector the pending request belongs to, so the address holds while stalled.
    assign master_address    = iph_q ? addr2_q : addr1_q;
    assign master_write      = 1'b0;
    assign master_writedata  = '0;
    assign accept            = master_read && !master_waitrequest;
    // Responses with nothing outstanding (idle or after a reset) are stale and dropped.
    assign rvalid            = master_readdatavalid && busy && out_q != '0;

    always_comb begin
        state_d = state_q;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        rem_d   = rem_q;
        iph_d   = iph_q;
        rph_d   = rvalid ? ~rph_q : rph_q;
        v1_d    = (rvalid && !rph_q) ? master_readdata[DATA_W-1:0] : v1_q;
        out_d   = out_q + OW'(accept) - OW'(rvalid);
        flush_d = state_q == S_FLUSH && !flush_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: if (start) begin
                addr1_d = base1_q;
                addr2_d = base2_q;
                s1_d    = str1_q;
                s2_d    = str2_q;
                rem_d   = len_q;
                iph_d   = 1'b0;
                rph_d   = 1'b0;
                done_d  = 1'b0;
                state_d = len_q == '0 ? S_FLUSH : S_ISSUE;
            end
            S_ISSUE: if (accept) begin
                iph_d = ~iph_q;
                if (iph_q) begin
                    addr1_d = addr1_q + s1_q;
                    addr2_d = addr2_q + s2_q;
                    rem_d   = rem_q - 32'd1;
                    state_d = rem_q == 32'd1 ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: if (out_q == '0) state_d = S_FLUSH;
            S_FLUSH: if (flush_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            {addr1_q, addr2_q, s1_q, s2_q, rem_q} <= '0;
            out_q   <= '0;
            {iph_q, rph_q, flush_q, done_q} <= '0;
            v1_q    <= '0;
        end else begin
            state_q <= state_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            iph_q   <= iph_d;
            rph_q   <= rph_d;
            flush_q <= flush_d;
            done_q  <= done_d;
            v1_q    <= v1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {base1_q, base2_q, len_q, str1_q, str2_q} <= '0;
        end else if (slave_write) begin
            case (slave_address)
                REG_BASE1: base1_q <= slave_writedata;
                REG_BASE2: base2_q <= slave_writedata;
                REG_LEN:   len_q   <= slave_writedata;
                REG_STR1:  str1_q  <= slave_writedata;
                REG_STR2:  str2_q  <= slave_writedata;
                default: ;
            endcase
        end
    end

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                REG_CTRL:  slave_readdata = 32'(acc);
                REG_BASE1: slave_readdata = base1_q;
                REG_BASE2: slave_readdata = base2_q;
                REG_LEN:   slave_readdata = len_q;
                REG_STR1:  slave_readdata = str1_q;
                REG_STR2:  slave_readdata = str2_q;
                REG_STAT: begin
                    slave_readdata[STAT_BUSY] = busy;
                    slave_readdata[STAT_DONE] = done_q;
                    slave_readdata[STAT_OVF]  = ovf;
                end
                default: ;
            endcase
        end
    end

    // Odd responses carry the vec2 element that completes a product with the held vec1 element.
    dot_stream_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start),
        .vld_i (rvalid && rph_q),
        .a_i   (v1_q),
        .b_i   (master_readdata[DATA_W-1:0]),
        .acc_o (acc),
        .ovf_o (ovf)
    );
endmodule

// File: tb/tb_dot_stream.sv
// tb_dot_stream: scoreboard bench for dot_stream with a latency/stall memory model.
module tb_dot_stream;
    localparam int MAX_OUT = 4;

    logic        clk, rst_n;
    logic        slave_waitrequest, slave_read, slave_write;
    logic [3:0]  slave_address;
    logic [31:0] slave_readdata, slave_writedata;
    logic        master_waitrequest, master_read, master_readdatavalid, master_write;
    logic [31:0] master_address, master_readdata, master_writedata;

    int n_chk, n_fail, cyc, outs, lat;
    bit ws_rand, chk_rd;
    logic [31:0] mem [logic [31:0]];
    typedef struct { int due; logic [31:0] data; } rsp_t;
    rsp_t        rq[$];
    logic [31:0] exp_addr[$];
    logic [31:0] rd_exp[$];
    string       rd_nm[$];
    int          acc_cyc[$];

    dot_stream #(.DATA_W(32), .FRAC_W(16), .MAX_OUT(MAX_OUT)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_readdata       (slave_readdata),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model: decides stall at the negedge, so accepts happen at the following posedge.
    initial begin
        cyc = 0;
        outs = 0;
        master_waitrequest = 0;
        master_readdatavalid = 0;
        master_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                master_readdatavalid = 1;
                master_readdata = rq[0].data;
                rq.delete(0);
                outs--;
            end else begin
                master_readdatavalid = 0;
                master_readdata = '0;
            end
            master_waitrequest = ws_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            if (master_read && !master_waitrequest) begin
                rq.push_back('{cyc + lat, mem.exists(master_address) ? mem[master_address] : 32'h0});
                outs++;
                acc_cyc.push_back(cyc);
                chk("outstanding_le_max", 32'(outs <= MAX_OUT), 32'd1);
                if (exp_addr.size() > 0) chk("master_address", master_address, exp_addr.pop_front());
            end
        end
    end

    // Read monitor: compares every checked CPU read against the scoreboard queue.
    always @(negedge clk) begin
        if (slave_read && !slave_waitrequest && chk_rd && rd_exp.size() > 0)
            chk(rd_nm.pop_front(), slave_readdata, rd_exp.pop_front());
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        slave_write = 1;
        slave_address = a;
        slave_writedata = d;
        for (int i = 0; i < 100 && slave_waitrequest; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        slave_write = 0;
    endtask

    task automatic cpu_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        slave_read = 1;
        slave_address = a;
        chk_rd = 1;
        rd_exp.push_back(exp);
        rd_nm.push_back(nm);
        @(posedge clk); #1;
        slave_read = 0;
        chk_rd = 0;
    endtask

    task automatic wait_idle(input int max, input string nm);
        bit bz;
        bz = 1;
        for (int i = 0; i < max && bz; i++) begin
            @(posedge clk); #1;
            slave_read = 1;
            slave_address = 4'd6;
            #1 bz = slave_readdata[0];
            slave_read = 0;
        end
        chk(nm, 32'(bz), 32'd0);
    endtask

    task automatic prog(input logic [31:0] b1, b2, len, s1, s2);
        cpu_write(4'd1, b1);
        cpu_write(4'd2, b2);
        cpu_write(4'd3, len);
        cpu_write(4'd4, s1);
        cpu_write(4'd5, s2);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        lat = 1;
        ws_rand = 0;
        chk_rd = 0;
        rst_n = 0;
        slave_read = 0;
        slave_write = 0;
        slave_address = '0;
        slave_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_master_read", 32'(master_read), 32'd0);
        chk("rst_master_address", master_address, 32'd0);
        chk("rst_master_write", {master_writedata[31:1], master_write}, 32'd0);
        chk("rst_slave_wait", 32'(slave_waitrequest), 32'd0);
        rst_n = 1;
        cpu_read(4'd6, 32'd0, "rst_status");
        cpu_read(4'd0, 32'd0, "rst_result");

        // Basic Q16.16 run: 1*0.5 + 2*0.5 + 3*0.5 = 3.0
        mem[32'h1000] = 32'h10000; mem[32'h1004] = 32'h20000; mem[32'h1008] = 32'h30000;
        mem[32'h2000] = 32'h8000;  mem[32'h2004] = 32'h8000;  mem[32'h2008] = 32'h8000;
        exp_addr = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
        prog(32'h1000, 32'h2000, 32'd3, 32'd4, 32'd4);
        acc_cyc.delete();
        cpu_write(4'd0, 32'd0);
        chk("start_to_first_read", 32'(master_read), 32'd1);
        wait_idle(50, "t1_idle");
        chk("t1_accepts", 32'(acc_cyc.size()), 32'd6);
        if (acc_cyc.size() == 6) chk("t1_back_to_back", 32'(acc_cyc[5] - acc_cyc[0]), 32'd5);
        cpu_read(4'd0, 32'h30000, "t1_result");
        cpu_read(4'd6, 32'd2, "t1_status");
        cpu_read(4'd1, 32'h1000, "base1_readback");
        cpu_read(4'd7, 32'd0, "unmapped_read");
        cpu_write(4'd9, 32'hFFFF_FFFF);
        cpu_read(4'd9, 32'd0, "unmapped_write");

        // Length 0: no traffic, short flush, result cleared
        cpu_write(4'd3, 32'd0);
        acc_cyc.delete();
        cpu_write(4'd0, 32'd0);
        wait_idle(3, "t2_busy_within_3");
        chk("t2_no_read", 32'(acc_cyc.size()), 32'd0);
        cpu_read(4'd0, 32'd0, "t2_result");
        cpu_read(4'd6, 32'd2, "t2_status");

        // Long latency, random stalls, length 16: sum 0..15 = 120.0
        for (int i = 0; i < 16; i++) begin
            mem[32'h3000 + 32'(4 * i)] = 32'(i) << 16;
            mem[32'h4000 + 32'(4 * i)] = 32'h10000;
        end
        lat = 10;
        ws_rand = 1;
        prog(32'h3000, 32'h4000, 32'd16, 32'd4, 32'd4);
        acc_cyc.delete();
        cpu_write(4'd0, 32'd0);
        @(posedge clk); #1;
        slave_read = 1;
        slave_address = 4'd0;
        #1 chk("busy_reg0_stall", 32'(slave_waitrequest), 32'd1);
        slave_address = 4'd1;
        #1 chk("busy_reg1_no_stall", 32'(slave_waitrequest), 32'd0);
        slave_read = 0;
        cpu_write(4'd1, 32'hDEAD0000);
        wait_idle(2000, "t3_idle");
        chk("t3_accepts", 32'(acc_cyc.size()), 32'd32);
        cpu_read(4'd0, 32'h780000, "t3_result");
        cpu_read(4'd1, 32'hDEAD0000, "t3_midrun_base1");
        ws_rand = 0;
        lat = 1;

        // Byte strides 8/12 with a negative element: 2 + 3 - 4 = 1.0
        mem[32'h100] = 32'h10000; mem[32'h108] = 32'h10000; mem[32'h110] = 32'h10000;
        mem[32'h800] = 32'h20000; mem[32'h80C] = 32'h30000; mem[32'h818] = 32'hFFFC0000;
        exp_addr = '{32'h100, 32'h800, 32'h108, 32'h80C, 32'h110, 32'h818};
        prog(32'h100, 32'h800, 32'd3, 32'd8, 32'd12);
        cpu_write(4'd0, 32'd0);
        wait_idle(50, "t4_idle");
        cpu_read(4'd0, 32'h10000, "t4_result");

        // Overflow: 181.0^2 twice exceeds the positive range
        mem[32'h5000] = 32'hB50000; mem[32'h5004] = 32'hB50000;
        prog(32'h5000, 32'h5000, 32'd2, 32'd4, 32'd4);
        cpu_write(4'd0, 32'd0);
        wait_idle(50, "t5_idle");
`ifdef DOT_SATURATE_EN
        cpu_read(4'd0, 32'h7FFFFFFF, "t5_result_sat");
        cpu_read(4'd6, 32'd6, "t5_status_sat");
`else
        cpu_read(4'd0, 32'hFFF20000, "t5_result_wrap");
        cpu_read(4'd6, 32'd2, "t5_status_wrap");
`endif

        // Asynchronous reset while draining, then a clean rerun: 0+1+2+3 = 6.0
        lat = 10;
        prog(32'h3000, 32'h4000, 32'd4, 32'd4, 32'd4);
        acc_cyc.delete();
        cpu_write(4'd0, 32'd0);
        for (int i = 0; i < 100 && acc_cyc.size() < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("t6_issued", 32'(acc_cyc.size()), 32'd8);
        #2 rst_n = 0;
        #1 chk("t6_rst_master_read", 32'(master_read), 32'd0);
        cpu_read(4'd6, 32'd0, "t6_rst_status");
        #1 rst_n = 1;
        repeat (25) @(posedge clk);
        cpu_read(4'd6, 32'd0, "t6_stale_ignored");
        prog(32'h3000, 32'h4000, 32'd4, 32'd4, 32'd4);
        cpu_write(4'd0, 32'd0);
        wait_idle(200, "t6_idle");
        cpu_read(4'd0, 32'h60000, "t6_result");
        cpu_read(4'd6, 32'd2, "t6_status");

        repeat (2) @(posedge clk);
        chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        chk("read_queue_drained", 32'(rd_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
